// File: rtl/sobel_launcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_launcher                                                  |
// | Function : issues one sobel call per frame of a batch; one call in flight. |
// | Option   : SOBEL_LAUNCHER_TIMEOUT_EN adds a watchdog on the WAIT state.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sobel_launcher #(
    parameter int ADDR_W         = 64,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [ADDR_W-1:0] cmd_dst_base,
    input  logic [31:0]       cmd_stride,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              sb_start,
    input  logic              sb_busy,
    output logic [ADDR_W-1:0] sb_image1,
    output logic [ADDR_W-1:0] sb_image2,
    input  logic              sb_done,
    output logic              sb_stall,
    output logic              active,
    output logic [CNT_W-1:0]  frames_done,
    output logic              batch_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [31:0]        r_stride;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_frames;
    logic               r_sb_start;
    logic               r_sb_stall;
    logic               r_active;
    logic               r_batch_done;
    logic               r_err;
    logic [ADDR_W-1:0]  w_stride_ext;
    logic [CNT_W-1:0]   w_frames_inc;
    logic               w_ret_acc;
    logic               w_timeout;

    generate
        if (ADDR_W > 32) begin : g_stride_wide
            assign w_stride_ext = {{(ADDR_W-32){1'b0}}, r_stride};
        end else begin : g_stride_narrow
            assign w_stride_ext = r_stride[ADDR_W-1:0];
        end
    endgenerate

    assign w_frames_inc = r_frames + CNT_W'(1);
    assign w_ret_acc    = sb_done && !r_sb_stall;

`ifdef SOBEL_LAUNCHER_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clock) begin
        if (reset || (r_state != S_WAIT)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == c_WD_LAST);
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_stride     <= '0;
            r_count      <= '0;
            r_frames     <= '0;
            r_sb_start   <= 1'b0;
            r_sb_stall   <= 1'b1;
            r_active     <= 1'b0;
            r_batch_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_batch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_src    <= cmd_src_base;
                        r_dst    <= cmd_dst_base;
                        r_stride <= cmd_stride;
                        r_count  <= cmd_count;
                        r_frames <= '0;
                        r_err    <= 1'b0;
                        if (cmd_count == '0) begin
                            r_batch_done <= 1'b1;
                        end else begin
                            r_state    <= S_LAUNCH;
                            r_sb_start <= 1'b1;
                            r_active   <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (!sb_busy) begin
                        r_state    <= S_WAIT;
                        r_sb_start <= 1'b0;
                        r_sb_stall <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_ret_acc) begin
                        r_frames   <= w_frames_inc;
                        r_sb_stall <= 1'b1;
                        if (w_frames_inc == r_count) begin
                            r_state      <= S_IDLE;
                            r_active     <= 1'b0;
                            r_batch_done <= 1'b1;
                        end else begin
                            r_src      <= r_src + w_stride_ext;
                            r_dst      <= r_dst + w_stride_ext;
                            r_state    <= S_LAUNCH;
                            r_sb_start <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_batch_done <= 1'b1;
                        r_sb_stall   <= 1'b1;
                        r_active     <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is withheld in the batch_done cycle so a new accept never lands on the pulse.
    assign cmd_ready   = (r_state == S_IDLE) && !r_batch_done && !reset;
    assign sb_start    = r_sb_start;
    assign sb_stall    = r_sb_stall;
    assign sb_image1   = r_src;
    assign sb_image2   = r_dst;
    assign active      = r_active;
    assign frames_done = r_frames;
    assign batch_done  = r_batch_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sobel_launcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sobel_launcher                                               |
// | Function : table-driven, randomized and directed checks of sobel_launcher. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sobel_launcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_src_base = '0;
    logic [63:0] cmd_dst_base = '0;
    logic [31:0] cmd_stride = '0;
    logic [15:0] cmd_count = '0;
    logic        sb_start;
    logic        sb_busy = 1'b0;
    logic [63:0] sb_image1;
    logic [63:0] sb_image2;
    logic        sb_done = 1'b0;
    logic        sb_stall;
    logic        active;
    logic [15:0] frames_done;
    logic        batch_done;
    logic        err;

    int total = 0;
    int bad = 0;
    int bd_total = 0;

    sobel_launcher #(
        .ADDR_W(64),
        .CNT_W(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_src_base(cmd_src_base),
        .cmd_dst_base(cmd_dst_base),
        .cmd_stride(cmd_stride),
        .cmd_count(cmd_count),
        .sb_start(sb_start),
        .sb_busy(sb_busy),
        .sb_image1(sb_image1),
        .sb_image2(sb_image2),
        .sb_done(sb_done),
        .sb_stall(sb_stall),
        .active(active),
        .frames_done(frames_done),
        .batch_done(batch_done),
        .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (batch_done === 1'b1) bd_total++;

    typedef struct {
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] stride;
        logic [15:0] count;
        int          busy_pct;
        int          dmin;
        int          dmax;
        logic [63:0] exp1;
        logic [63:0] exp2;
        logic [15:0] exp_frames;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [63:0] s, input logic [63:0] d,
                             input logic [31:0] st, input logic [15:0] c);
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clock);
        chk("cmd_ready before issue", 64'(cmd_ready), 64'd1);
        cmd_valid    = 1'b1;
        cmd_src_base = s;
        cmd_dst_base = d;
        cmd_stride   = st;
        cmd_count    = c;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Drives one batch as a randomized sobel peer and checks it against the
    // frame arithmetic: call i uses base + i*stride, one return per call.
    task automatic run_batch(input logic [63:0] src, input logic [63:0] dst,
                             input logic [31:0] stride, input logic [15:0] count,
                             input int busy_pct, input int dmin, input int dmax,
                             output logic [63:0] last1, output logic [63:0] last2,
                             output logic [15:0] fdone);
        int calls = 0, rets = 0, pend = -1, viol = 0, bd_seen = 0;
        logic prev_hold = 1'b0, ret_prev = 1'b0, waiting, exp_bd;
        logic [63:0] hold1 = '0, hold2 = '0, e1, e2;
        last1 = '0;
        last2 = '0;
        issue_cmd(src, dst, stride, count);
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_bd = (count == 16'd0) ? (cyc == 0) : (ret_prev && rets == int'(count));
            if (batch_done !== exp_bd) viol++;
            if (frames_done !== 16'(rets)) viol++;
            if (err !== 1'b0) viol++;
            if (cmd_ready !== 1'b0) viol++;
            if (prev_hold && (sb_start !== 1'b1 || sb_image1 !== hold1 || sb_image2 !== hold2)) viol++;
            if (batch_done === 1'b1) begin
                bd_seen = 1;
                break;
            end
            waiting = (calls > rets);
            if (sb_stall !== !waiting) viol++;
            if (active !== (count != 16'd0)) viol++;
            if (sb_start !== (!waiting && rets < int'(count))) viol++;
            ret_prev  = 1'b0;
            prev_hold = 1'b0;
            sb_busy   = 1'b0;
            sb_done   = 1'b0;
            if (sb_start === 1'b1) begin
                e1 = src + 64'(calls) * {32'h0, stride};
                e2 = dst + 64'(calls) * {32'h0, stride};
                if (sb_image1 !== e1 || sb_image2 !== e2) viol++;
                if (int'($urandom_range(99)) < busy_pct) begin
                    sb_busy   = 1'b1;
                    prev_hold = 1'b1;
                    hold1     = sb_image1;
                    hold2     = sb_image2;
                end else begin
                    calls++;
                    last1 = sb_image1;
                    last2 = sb_image2;
                    pend  = int'($urandom_range(dmax, dmin));
                end
            end
            if (waiting) begin
                if (pend <= 0) begin
                    sb_done  = 1'b1;
                    rets++;
                    ret_prev = 1'b1;
                    pend     = -1;
                end else begin
                    pend--;
                end
            end else begin
                sb_done = ($urandom_range(3) == 0);
            end
            cmd_valid    = $urandom_range(1) == 1;
            cmd_count    = 16'($urandom);
            cmd_src_base = {$urandom, $urandom};
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        sb_done   = 1'b0;
        sb_busy   = 1'b0;
        fdone     = frames_done;
        chk("batch invariants", 64'(viol), 64'd0);
        chk("batch_done seen", 64'(bd_seen), 64'd1);
        chk("calls issued", 64'(calls), 64'(count));
        chk("idle sb_start at end", 64'(sb_start), 64'd0);
        chk("active low at end", 64'(active), 64'd0);
        @(negedge clock);
        chk("batch_done single pulse", 64'(batch_done), 64'd0);
        chk("cmd_ready after batch", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        vec_t        tbl[5];
        logic [63:0] l1, l2, rs, rd;
        logic [31:0] rst_stride;
        logic [15:0] fd, rc;
        int          stable, bd_before, n;

        tbl[0] = '{64'h1000, 64'h8000, 32'h400, 16'd3, 0, 4, 4, 64'h1800, 64'h8800, 16'd3};
        tbl[1] = '{64'h5000, 64'h6000, 32'h10, 16'd0, 0, 0, 0, 64'h0, 64'h0, 16'd0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FC00, 64'h1_0000, 32'h400, 16'd2, 0, 0, 2,
                   64'h0, 64'h1_0400, 16'd2};
        tbl[3] = '{64'h40, 64'h80, 32'h0, 16'd4, 50, 0, 3, 64'h40, 64'h80, 16'd4};
        tbl[4] = '{64'hA000, 64'hB000, 32'hFFFF_FFFF, 16'd2, 30, 1, 3,
                   64'h1_0000_9FFF, 64'h1_0000_AFFF, 16'd2};

        // Reset values
        repeat (3) @(negedge clock);
        chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset sb_start", 64'(sb_start), 64'd0);
        chk("reset sb_stall", 64'(sb_stall), 64'd1);
        chk("reset active", 64'(active), 64'd0);
        chk("reset frames_done", 64'(frames_done), 64'd0);
        chk("reset batch_done", 64'(batch_done), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset image1", sb_image1, 64'd0);
        chk("reset image2", sb_image2, 64'd0);
        reset = 1'b0;
        #1;
        chk("cmd_ready after reset", 64'(cmd_ready), 64'd1);
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            run_batch(tbl[i].src, tbl[i].dst, tbl[i].stride, tbl[i].count,
                      tbl[i].busy_pct, tbl[i].dmin, tbl[i].dmax, l1, l2, fd);
            chk($sformatf("vec%0d last image1", i), l1, tbl[i].exp1);
            chk($sformatf("vec%0d last image2", i), l2, tbl[i].exp2);
            chk($sformatf("vec%0d frames_done", i), 64'(fd), 64'(tbl[i].exp_frames));
        end

        // Spurious returns while idle
        bd_before = bd_total;
        sb_done = 1'b1;
        repeat (3) @(negedge clock);
        sb_done = 1'b0;
        @(negedge clock);
        chk("idle sb_done frames", 64'(frames_done), 64'd2);
        chk("idle sb_done batch_done", 64'(bd_total - bd_before), 64'd0);
        chk("idle sb_done active", 64'(active), 64'd0);

        // Randomized batches
        for (int i = 0; i < 6; i++) begin
            rs = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            rst_stride = $urandom;
            rc = 16'($urandom_range(5, 1));
            run_batch(rs, rd, rst_stride, rc, 40, 0, 4, l1, l2, fd);
            chk("rand last image1", l1, rs + 64'(rc - 16'd1) * {32'h0, rst_stride});
            chk("rand last image2", l2, rd + 64'(rc - 16'd1) * {32'h0, rst_stride});
            chk("rand frames_done", 64'(fd), 64'(rc));
        end

        // Busy held four cycles in LAUNCH
        issue_cmd(64'h2000, 64'h3000, 32'h10, 16'd1);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (sb_start === 1'b1 && sb_image1 === 64'h2000 && sb_image2 === 64'h3000) stable++;
            sb_busy = (i < 4);
            @(negedge clock);
        end
        chk("busy stable cycles", 64'(stable), 64'd5);
        chk("busy single call", 64'(sb_start), 64'd0);
        chk("busy in wait", 64'(sb_stall), 64'd0);
        sb_done = 1'b1;
        @(negedge clock);
        sb_done = 1'b0;
        chk("busy batch_done", 64'(batch_done), 64'd1);
        chk("busy frames_done", 64'(frames_done), 64'd1);
        @(negedge clock);

        // Reset mid-batch while waiting on the second frame
        issue_cmd(64'h100, 64'h200, 32'h40, 16'd3);
        sb_done = 1'b0;
        @(negedge clock);
        chk("midreset in wait", 64'(sb_stall), 64'd0);
        sb_done = 1'b1;
        @(negedge clock);
        sb_done = 1'b0;
        chk("midreset one frame", 64'(frames_done), 64'd1);
        @(negedge clock);
        chk("midreset second wait", 64'(sb_stall), 64'd0);
        bd_before = bd_total;
        reset   = 1'b1;
        sb_done = 1'b1;
        @(negedge clock);
        chk("midreset frames_done", 64'(frames_done), 64'd0);
        chk("midreset active", 64'(active), 64'd0);
        chk("midreset sb_stall", 64'(sb_stall), 64'd1);
        chk("midreset cmd_ready", 64'(cmd_ready), 64'd0);
        chk("midreset image1", sb_image1, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        sb_done = 1'b0;
        chk("late sb_done frames", 64'(frames_done), 64'd0);
        chk("midreset no batch_done", 64'(bd_total - bd_before), 64'd0);
        run_batch(64'h700, 64'h900, 32'h8, 16'd2, 20, 0, 2, l1, l2, fd);
        chk("post-reset image1", l1, 64'h708);
        chk("post-reset frames", 64'(fd), 64'd2);

        // Withheld return: watchdog or unbounded wait
        issue_cmd(64'h4000, 64'h5000, 32'h100, 16'd1);
        @(negedge clock);
        chk("withhold in wait", 64'(sb_stall), 64'd0);
`ifdef SOBEL_LAUNCHER_TIMEOUT_EN
        n = 0;
        while (batch_done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("timeout latency", 64'(n), 64'd16);
        chk("timeout err", 64'(err), 64'd1);
        chk("timeout frames_done", 64'(frames_done), 64'd0);
        chk("timeout active", 64'(active), 64'd0);
        @(negedge clock);
        chk("timeout err sticky", 64'(err), 64'd1);
        issue_cmd(64'h0, 64'h0, 32'h1, 16'd0);
        chk("err cleared by cmd", 64'(err), 64'd0);
`else
        bd_before = bd_total;
        repeat (40) @(negedge clock);
        chk("no timeout still waiting", 64'(sb_stall), 64'd0);
        chk("no timeout active", 64'(active), 64'd1);
        chk("no timeout err", 64'(err), 64'd0);
        chk("no timeout batch_done", 64'(bd_total - bd_before), 64'd0);
        sb_done = 1'b1;
        @(negedge clock);
        sb_done = 1'b0;
        chk("late return batch_done", 64'(batch_done), 64'd1);
        chk("late return frames", 64'(frames_done), 64'd1);
`endif
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
